encoder_8_3_req: RTL and testbench
==================================

# encoder_8_3_req

Sequential 8-to-3 request encoder: the inverse of the team's 3-to-8 decoder. It captures one-hot or multi-hot requests on an 8-bit input into a sticky pending register. It presents the binary index of the selected pending request with a valid/acknowledge handshake, and clears that request only when it is acknowledged. It sits in front of the decoder so a downstream consumer can service requests one at a time and re-expand the index.

## Interface
- Parameters: none. Widths are fixed: 8 request lines, 3-bit index.
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- E  input  1  enable; when 0, In is not captured
- In  input  8  request lines; bit i requests index i
- Out  output  3  encoded index of the presented request; reset 3'b000
- V  output  1  Out is valid; reset 0
- Ack  input  1  consumer accepts Out; only meaningful while V=1

## Operation
- Pending register pend[7:0], reset 8'h00.
- Every edge: pend <= (pend & ~clr) | (E ? In : 8'h00).
  - clr is one-hot at Out when V=1 and Ack=1; otherwise clr = 0.
  - Set beats clear: if In[Out]=1 with E=1 in the same cycle as the Ack, the bit stays pending.
- State machine, two states:
  - IDLE (reset state), V=0. If pend != 0, latch sel(pend) into Out, set V=1 and go to PRESENT. Otherwise stay. The pend value used is the registered value, not In.
  - PRESENT, V=1. Out and V are held stable. On Ack=1, clear pend[Out], set V<=0 and go to IDLE. If Ack=0, stay.
- Out keeps its last value in IDLE and is not zeroed.
- sel() with fixed priority: the highest set index wins (7 highest, 0 lowest).
- Ack while V=0 is ignored and has no effect on pend.
- E=0 blocks only capture. Pending requests continue to be presented and acknowledged.
- In bits are treated as levels. A bit held high re-sets pend every cycle, so the same index is re-presented after its Ack.
- An async reset mid-handshake forces IDLE, V=0, Out=0, pend=0 immediately.

## Timing
- Request to valid: In[i] high at edge k with E=1 sets pend[i] after edge k. V=1 with Out=i follows after edge k+1, a 2-cycle latency when idle.
- Ack to next valid: Ack sampled at edge m drops V after m. If other requests are pending, V rises after edge m+1. Peak throughput is one grant per 2 cycles.
- V, Out and pend are all registered. No combinational path from In or Ack to Out or V.
- All 8 requests pending drains in 16 cycles.

## Configuration
- Macro ROUND_ROBIN_EN.
- When defined, a 3-bit register last (reset 3'd0) records each granted index on Ack. sel() then searches descending from last-1, wrapping 0→7. The first search after reset therefore starts at 7, the same order as fixed priority. No index can starve.
- When undefined: fixed priority as above, and the last register is not instantiated.

## Structure
- Shared package enc_pkg:
  - constants REQ_W=8 and IDX_W=3
  - state enum with IDLE and PRESENT
- Sub-module priority_enc_8_3: purely combinational.
  - Inputs: 8-bit vector and 3-bit start index.
  - Outputs: 3-bit index and an any-bit flag.
  - In fixed mode it is instantiated with start=7.
- The top level holds pend, the FSM, Out/V registers and, under ROUND_ROBIN_EN, the last register.

## Test plan
- Reset with In=8'hFF, E=1, rst_n=0 → V=0, Out=0, pend=0 throughout. Release → V=1, Out=7 two edges later.
- E=0, In=8'h24 for 3 cycles → V stays 0. Then E=1 for one cycle → V=1, Out=5. Ack → V=0, then V=1, Out=2. Ack → V=0 and stays 0.
- Pulse In=8'h81 with E=1, then hold Ack=1 continuously → Out sequence 7 then 0, V pattern 1,0,1,0. No Ack while V=0 alters pend.
- Hold In=8'h08 with E=1 during Ack of index 3 → index 3 re-presented 2 cycles later (set beats clear).
- Assert rst_n=0 while V=1 and Out=6 → V and Out drop asynchronously before the next edge. After release, V stays 0 with In=0.
- ROUND_ROBIN_EN defined, In=8'h90 held high → grants alternate 7,4,7,4. Without the macro, the grants are 7,7,7.

Source files
------------

// File: rtl/enc_pkg.sv
// Shared widths, FSM state type and index helper for the 8-to-3 request encoder.
// Imported by priority_enc_8_3 and encoder_8_3_req.
package enc_pkg;

    localparam int REQ_W = 8;
    localparam int IDX_W = 3;

    typedef enum logic {
        IDLE    = 1'b0,
        PRESENT = 1'b1
    } state_t;

    // One-hot request mask for a binary index.
    function automatic logic [REQ_W-1:0] idx_onehot(input logic [IDX_W-1:0] idx);
        return REQ_W'(1) << idx;
    endfunction

endpackage

// File: rtl/priority_enc_8_3.sv
// Combinational wrap-around priority encoder: searches req downward from start
// (start, start-1, ..., wrapping 0 -> 7) and returns the first set index.
module priority_enc_8_3
    import enc_pkg::*;
(
    input  logic [7:0] req,
    input  logic [2:0] start,
    output logic [2:0] idx,
    output logic       any
);

    logic [7:0] rot;
    logic [2:0] src;
    logic [2:0] off;

    // Rotate so that req[start] lands at rot[7]; a plain highest-bit search
    // over rot then walks req downward from start with wrap-around.
    always_comb begin
        rot = '0;
        src = '0;
        for (int j = 0; j < REQ_W; j++) begin
            src    = start + IDX_W'(j + 1);
            rot[j] = req[src];
        end
    end

    always_comb begin
        off = '0;
        for (int j = 0; j < REQ_W; j++) begin
            if (rot[j]) begin
                off = IDX_W'(j);
            end
        end
    end

    assign idx = start + off + 3'd1;
    assign any = |req;

endmodule

// File: rtl/encoder_8_3_req.sv
// Sequential 8-to-3 request encoder with sticky pending bits and a V/Ack
// handshake. Define ROUND_ROBIN_EN for rotating priority; default is fixed (7 highest).
module encoder_8_3_req
    import enc_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       E,
    input  logic [7:0] In,
    output logic [2:0] Out,
    output logic       V,
    input  logic       Ack
);

    // Handshake: Out is valid while V=1 and is held stable until Ack is seen
    // high on a rising edge with V=1; that edge is the grant. Ack with V=0 is ignored.

    state_t     state;
    logic [7:0] pend;
    logic [7:0] clr;
    logic [7:0] set_vec;
    logic [2:0] sel_start;
    logic [2:0] sel_idx;
    logic       sel_any;
    logic       grant;

    assign grant   = V && Ack;
    assign clr     = grant ? idx_onehot(Out) : 8'h00;
    assign set_vec = E ? In : 8'h00;

`ifdef ROUND_ROBIN_EN
    logic [2:0] last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last <= 3'd0;
        end else if (grant) begin
            last <= Out;
        end
    end

    // Start one below the last grant; after reset this is 7, matching fixed order.
    assign sel_start = last - 3'd1;
`else
    assign sel_start = 3'd7;
`endif

    priority_enc_8_3 u_sel (
        .req   (pend),
        .start (sel_start),
        .idx   (sel_idx),
        .any   (sel_any)
    );

    // Set beats clear: a request re-asserted during its own grant stays pending.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend <= 8'h00;
        end else begin
            pend <= (pend & ~clr) | set_vec;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            Out   <= 3'd0;
            V     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (sel_any) begin
                        Out   <= sel_idx;
                        V     <= 1'b1;
                        state <= PRESENT;
                    end
                end
                PRESENT: begin
                    if (Ack) begin
                        V     <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    V     <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_encoder_8_3_req.sv
// Bench for encoder_8_3_req: directed scenarios with literal expectations plus
// random stimulus checked every cycle against a behavioural model.
module tb_encoder_8_3_req;

    logic       clk;
    logic       rst_n;
    logic       E;
    logic [7:0] In;
    logic [2:0] Out;
    logic       V;
    logic       Ack;

    int checks = 0;
    int errors = 0;

    logic [2:0] exp_q[$];

    encoder_8_3_req dut (
        .clk   (clk),
        .rst_n (rst_n),
        .E     (E),
        .In    (In),
        .Out   (Out),
        .V     (V),
        .Ack   (Ack)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- behavioural model ----------------
    logic [7:0] m_pend;
    logic       m_v;
    logic [2:0] m_out;
`ifdef ROUND_ROBIN_EN
    logic [2:0] m_last;
`endif

    // First set index when walking downward from s with wrap-around.
    function automatic logic [2:0] m_pick(input logic [7:0] p, input int s);
        for (int k = 0; k < 8; k++) begin
            if (p[(s - k + 8) % 8]) return 3'((s - k + 8) % 8);
        end
        return 3'd0;
    endfunction

    function automatic int m_start();
`ifdef ROUND_ROBIN_EN
        return (int'(m_last) + 7) % 8;
`else
        return 7;
`endif
    endfunction

    always @(posedge clk or negedge rst_n) begin
        logic [7:0] keep;
        if (!rst_n) begin
            m_pend <= 8'h00;
            m_v    <= 1'b0;
            m_out  <= 3'd0;
`ifdef ROUND_ROBIN_EN
            m_last <= 3'd0;
`endif
        end else begin
            keep = m_pend;
            if (m_v && Ack) keep[m_out] = 1'b0;
            m_pend <= keep | (E ? In : 8'h00);
            if (!m_v && m_pend != 8'h00) begin
                m_v   <= 1'b1;
                m_out <= m_pick(m_pend, m_start());
            end else if (m_v && Ack) begin
                m_v <= 1'b0;
`ifdef ROUND_ROBIN_EN
                m_last <= m_out;
`endif
            end
        end
    end

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        check("model_v", int'(V), int'(m_v));
        check("model_out", int'(Out), int'(m_out));
    end

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        E     = 1'b0;
        In    = 8'h00;
        Ack   = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_valid(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (V) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL wait_valid: V=%0d expected 1 within %0d cycles", V, budget);
        end
    endtask

    // ---------------- directed + random stimulus ----------------
    initial begin
        bit ok;
        int grants;

        rst_n = 1'b0;
        E     = 1'b1;
        In    = 8'hFF;
        Ack   = 1'b0;

        // reset held with all requests active
        repeat (3) begin
            @(negedge clk);
            check("rst_v", int'(V), 0);
            check("rst_out", int'(Out), 0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        check("rel_v_lat1", int'(V), 0);
        @(negedge clk);
        check("rel_v", int'(V), 1);
        check("rel_out", int'(Out), 7);

        // enable gating
        do_reset();
        E  = 1'b0;
        In = 8'h24;
        repeat (3) begin
            @(negedge clk);
            check("e0_v", int'(V), 0);
        end
        E = 1'b1;
        @(negedge clk);
        E  = 1'b0;
        In = 8'h00;
        check("e1_v_lat1", int'(V), 0);
        @(negedge clk);
        check("e1_v", int'(V), 1);
        check("e1_out5", int'(Out), 5);
        Ack = 1'b1;
        @(negedge clk);
        check("e1_ack_v", int'(V), 0);
        Ack = 1'b0;
        @(negedge clk);
        check("e1_v2", int'(V), 1);
        check("e1_out2", int'(Out), 2);
        Ack = 1'b1;
        @(negedge clk);
        check("e1_ack2_v", int'(V), 0);
        Ack = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("e1_empty_v", int'(V), 0);
        end

        // pulse 0x81, Ack held high throughout
        do_reset();
        E   = 1'b1;
        In  = 8'h81;
        Ack = 1'b1;
        @(negedge clk);
        E  = 1'b0;
        In = 8'h00;
        check("p81_v0", int'(V), 0);
        @(negedge clk);
        check("p81_v1", int'(V), 1);
        check("p81_out7", int'(Out), 7);
        @(negedge clk);
        check("p81_v2", int'(V), 0);
        @(negedge clk);
        check("p81_v3", int'(V), 1);
        check("p81_out0", int'(Out), 0);
        @(negedge clk);
        check("p81_v4", int'(V), 0);
        repeat (3) begin
            @(negedge clk);
            check("p81_idle_v", int'(V), 0);
        end
        Ack = 1'b0;

        // set beats clear
        do_reset();
        E  = 1'b1;
        In = 8'h08;
        @(negedge clk);
        check("sbc_v0", int'(V), 0);
        @(negedge clk);
        check("sbc_v1", int'(V), 1);
        check("sbc_out3", int'(Out), 3);
        Ack = 1'b1;
        @(negedge clk);
        check("sbc_ack_v", int'(V), 0);
        Ack = 1'b0;
        @(negedge clk);
        check("sbc_re_v", int'(V), 1);
        check("sbc_re_out3", int'(Out), 3);
        E  = 1'b0;
        In = 8'h00;

        // async reset mid-handshake
        do_reset();
        E  = 1'b1;
        In = 8'h40;
        @(negedge clk);
        E  = 1'b0;
        In = 8'h00;
        @(negedge clk);
        check("ar_v_pre", int'(V), 1);
        check("ar_out6", int'(Out), 6);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_v_async", int'(V), 0);
        check("ar_out_async", int'(Out), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("ar_after_v", int'(V), 0);
        end

        // full drain of 8 requests in 16 cycles, Ack held high
        do_reset();
        E   = 1'b1;
        In  = 8'hFF;
        Ack = 1'b1;
        for (int i = 7; i >= 0; i--) exp_q.push_back(3'(i));
        @(negedge clk);
        E  = 1'b0;
        In = 8'h00;
        grants = 0;
        repeat (16) begin
            @(negedge clk);
            if (V && exp_q.size() > 0) begin
                check("drain_out", int'(Out), int'(exp_q.pop_front()));
                grants++;
            end
        end
        check("drain_grants", grants, 8);
        @(negedge clk);
        check("drain_done_v", int'(V), 0);
        Ack = 1'b0;
        exp_q.delete();

        // held 0x90: rotating vs fixed priority
        do_reset();
        E  = 1'b1;
        In = 8'h90;
`ifdef ROUND_ROBIN_EN
        exp_q.push_back(3'd7);
        exp_q.push_back(3'd4);
        exp_q.push_back(3'd7);
        exp_q.push_back(3'd4);
`else
        exp_q.push_back(3'd7);
        exp_q.push_back(3'd7);
        exp_q.push_back(3'd7);
`endif
        while (exp_q.size() > 0) begin
            wait_valid(6, ok);
            if (!ok) break;
            check("hold90_grant", int'(Out), int'(exp_q.pop_front()));
            Ack = 1'b1;
            @(negedge clk);
            Ack = 1'b0;
        end
        exp_q.delete();
        do_reset();

        // random traffic
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if ($urandom_range(0, 499) == 0) begin
                rst_n = 1'b0;
            end else begin
                rst_n = 1'b1;
            end
            E   = ($urandom_range(0, 3) != 0);
            In  = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
            Ack = ($urandom_range(0, 2) != 0);
        end
        rst_n = 1'b1;
        E     = 1'b0;
        In    = 8'h00;
        Ack   = 1'b0;
        repeat (4) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
